// File: rtl/seq_signed_divider.sv
// Multi-cycle signed restoring divider: one shift-subtract step per clock on operand
// magnitudes, with sign fix-up, divide-by-zero and overflow flags applied in a final cycle.
module seq_signed_divider #(
  parameter int WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o,
  output logic             overflow_o
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, refilled with quotient bits
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] quo_res_q, quo_res_d, rem_res_q, rem_res_d;
  logic             dz_res_q, dz_res_d, ovf_res_q, ovf_res_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dsr_q};

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    orig_d    = orig_q;
    cnt_d     = cnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    quo_res_d = quo_res_q;
    rem_res_d = rem_res_q;
    dz_res_d  = dz_res_q;
    ovf_res_d = ovf_res_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          // Magnitudes are WIDTH-bit unsigned, so the most negative operand still fits.
          dvd_d   = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
          dsr_d   = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;
          orig_d  = dividend_i;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH);
          qneg_d  = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
          rneg_d  = dividend_i[WIDTH-1];
          dz_d    = (divisor_i == '0);
          ovf_d   = (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor_i == '1);
          state_d = CALC;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // The terminal-count cycle hands over to FIX without stepping.
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          if (!trial[WIDTH+1]) begin
            rem_d = trial[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        if (dz_q) begin
          quo_res_d = '1;
          rem_res_d = orig_q;
          dz_res_d  = 1'b1;
          ovf_res_d = 1'b0;
        end else begin
          quo_res_d = qneg_q ? -dvd_q : dvd_q;
          rem_res_d = rneg_q ? -rem_q : rem_q;
          dz_res_d  = 1'b0;
          ovf_res_d = ovf_q;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      orig_q    <= '0;
      cnt_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      quo_res_q <= '0;
      rem_res_q <= '0;
      dz_res_q  <= 1'b0;
      ovf_res_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      orig_q    <= orig_d;
      cnt_q     <= cnt_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      quo_res_q <= quo_res_d;
      rem_res_q <= rem_res_d;
      dz_res_q  <= dz_res_d;
      ovf_res_q <= ovf_res_d;
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign quotient_o    = quo_res_q;
  assign remainder_o   = rem_res_q;
  assign div_by_zero_o = dz_res_q;
  assign overflow_o    = ovf_res_q;
endmodule
